// File: rtl/sipo_deser_pkg.sv
// Shared definitions for the sipo_deser serial-to-parallel deserializer:
// FSM state encoding, default parameter values and the bit-counter width helper.
package sipo_deser_pkg;

    localparam int DEFAULT_WIDTH = 4;
    localparam int DEFAULT_CNT_W = 16;

    // Bit-counter width for the default word width.
    localparam int DEFAULT_BIT_CNT_W = $clog2(DEFAULT_WIDTH + 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Bit counter must hold values 0..width, hence width+1 codes.
    function automatic int bit_cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/sipo_hold_reg.sv
// One-entry output holding register with valid/ready handshake.
// A new word is accepted when the register is empty or is being drained in the
// same cycle; otherwise the new word is dropped and the sticky overrun flag set.
module sipo_hold_reg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             out_ready,
    input  logic             err_clr,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             overrun,
    output logic             load_ok
);

    logic drain;
    logic drop;

    assign drain   = out_valid && out_ready;
    assign load_ok = in_valid && (!out_valid || out_ready);
    assign drop    = in_valid && out_valid && !out_ready;

    // Load a new word or release the held one; a load in a drain cycle keeps valid high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (load_ok) begin
            out_data  <= in_data;
            out_valid <= 1'b1;
        end else if (drain) begin
            out_valid <= 1'b0;
        end
    end

    // Sticky overrun flag; a drop in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun <= 1'b0;
        end else if (drop) begin
            overrun <= 1'b1;
        end else if (err_clr) begin
            overrun <= 1'b0;
        end
    end

endmodule

// File: rtl/sipo_deser.sv
// Serial-in/parallel-out deserializer for the MSB-first stream of the PISO
// serializer. A sync pulse on a valid bit marks the MSB of a word; WIDTH valid
// bits later the word is handed to a one-entry holding register.
// Optional feature: define SIPO_DESER_WORD_CNT_EN to build the delivered-word
// counter on word_cnt; otherwise word_cnt is constant zero.
module sipo_deser
    import sipo_deser_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ser_in,
    input  logic             ser_valid,
    input  logic             sync,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overrun,
    output logic             frame_err,
    input  logic             err_clr,
    output logic [CNT_W-1:0] word_cnt
);

    localparam int BCW = bit_cnt_width(WIDTH);

    // Only WIDTH-1 bits need storing: the last bit of a word comes straight from ser_in.
    logic [WIDTH-2:0] shift_reg;
    logic [BCW-1:0]   bit_cnt;
    state_t           state;

    logic [WIDTH-1:0] new_word;
    logic             last_bit;
    logic             word_done;
    logic             frame_evt;
    logic             loaded;

    assign new_word  = {shift_reg, ser_in};
    assign last_bit  = (bit_cnt == BCW'(WIDTH - 1));
    assign frame_evt = ser_valid && sync && (state == SHIFT);
    assign word_done = ser_valid && !sync && (state == SHIFT) && last_bit;

    // Word-alignment FSM with shift register and bit counter; invalid cycles hold everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
            state     <= IDLE;
        end else if (ser_valid) begin
            unique case (state)
                IDLE: begin
                    if (sync) begin
                        shift_reg <= (WIDTH-1)'(ser_in);
                        bit_cnt   <= BCW'(1);
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (sync) begin
                        shift_reg <= (WIDTH-1)'(ser_in);
                        bit_cnt   <= BCW'(1);
                    end else if (last_bit) begin
                        shift_reg <= new_word[WIDTH-2:0];
                        bit_cnt   <= '0;
                        state     <= IDLE;
                    end else begin
                        shift_reg <= new_word[WIDTH-2:0];
                        bit_cnt   <= bit_cnt + BCW'(1);
                    end
                end
                default: begin
                    shift_reg <= '0;
                    bit_cnt   <= '0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    // Sticky framing error: a new sync while a word is in progress; wins over err_clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_err <= 1'b0;
        end else if (frame_evt) begin
            frame_err <= 1'b1;
        end else if (err_clr) begin
            frame_err <= 1'b0;
        end
    end

    sipo_hold_reg #(
        .WIDTH(WIDTH)
    ) u_hold (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (word_done),
        .in_data  (new_word),
        .out_ready(out_ready),
        .err_clr  (err_clr),
        .out_data (out_data),
        .out_valid(out_valid),
        .overrun  (overrun),
        .load_ok  (loaded)
    );

`ifdef SIPO_DESER_WORD_CNT_EN
    logic [CNT_W-1:0] word_cnt_q;

    // Count every word loaded into the holding register; wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt_q <= '0;
        end else if (loaded) begin
            word_cnt_q <= word_cnt_q + CNT_W'(1);
        end
    end

    assign word_cnt = word_cnt_q;
`else
    logic unused_loaded;

    assign unused_loaded = loaded;
    assign word_cnt      = '0;
`endif

endmodule

// File: tb/tb_sipo_deser.sv
// Self-checking bench for sipo_deser (WIDTH=4). Delivered words are checked by
// a scoreboard queue; flags, latency and reset behaviour by directed checks.
module tb_sipo_deser;

    localparam int W  = 4;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ser_in;
    logic          ser_valid;
    logic          sync;
    logic [W-1:0]  out_data;
    logic          out_valid;
    logic          out_ready;
    logic          overrun;
    logic          frame_err;
    logic          err_clr;
    logic [CW-1:0] word_cnt;

    int            checks  = 0;
    int            errors  = 0;
    int            exp_cnt = 0;
    logic [W-1:0]  sb[$];
    logic [W-1:0]  sb_exp;

    sipo_deser #(
        .WIDTH(W),
        .CNT_W(CW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ser_in   (ser_in),
        .ser_valid(ser_valid),
        .sync     (sync),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .overrun  (overrun),
        .frame_err(frame_err),
        .err_clr  (err_clr),
        .word_cnt (word_cnt)
    );

    // Free-running 10-time-unit clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    // Drive one cycle of serial inputs; returns 1 time unit after the sampling edge.
    task automatic applyStimulus(input logic v, input logic s, input logic b);
        ser_valid = v;
        sync      = s;
        ser_in    = b;
        @(posedge clk);
        #1;
    endtask

    task automatic sendWord(input logic [W-1:0] w, input bit push);
        if (push) sb.push_back(w);
        for (int i = W - 1; i >= 0; i--) applyStimulus(1'b1, (i == W - 1), w[i]);
        ser_valid = 1'b0;
        sync      = 1'b0;
    endtask

    function automatic logic [31:0] expCnt();
`ifdef SIPO_DESER_WORD_CNT_EN
        return 32'(exp_cnt);
`else
        return 32'd0;
`endif
    endfunction

    // Scoreboard: every handshake must deliver the oldest expected word.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checkOutput("sb_extra", 32'(out_valid), 32'd0);
            end else begin
                sb_exp = sb.pop_front();
                checkOutput("sb_word", 32'(out_data), 32'(sb_exp));
            end
        end
    end

    // Global time bound so the bench always terminates.
    initial begin
        #200000;
        $display("[TB] FAIL timeout actual=running required=finished");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst_n     = 1'b0;
        ser_in    = 1'b0;
        ser_valid = 1'b0;
        sync      = 1'b0;
        out_ready = 1'b1;
        err_clr   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_data", 32'(out_data), 32'd0);
        checkOutput("rst_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_overrun", 32'(overrun), 32'd0);
        checkOutput("rst_frame", 32'(frame_err), 32'd0);
        checkOutput("rst_cnt", 32'(word_cnt), 32'd0);
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);

        // Basic word 4'hB with latency check.
        sb.push_back(4'hB);
        applyStimulus(1'b1, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("lat_early", 32'(out_valid), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b1);
        ser_valid = 1'b0;
        sync      = 1'b0;
        exp_cnt   = 1;
        checkOutput("b_valid", 32'(out_valid), 32'd1);
        checkOutput("b_data", 32'(out_data), 32'hB);
        checkOutput("b_cnt", 32'(word_cnt), expCnt());
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("b_drained", 32'(out_valid), 32'd0);

        // Back-to-back words.
        sendWord(4'hA, 1'b1);
        checkOutput("a_data", 32'(out_data), 32'hA);
        checkOutput("a_valid", 32'(out_valid), 32'd1);
        sendWord(4'h5, 1'b1);
        checkOutput("five_data", 32'(out_data), 32'h5);
        checkOutput("b2b_overrun", 32'(overrun), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        exp_cnt = 3;

        // Overrun with stalled consumer, then clear.
        out_ready = 1'b0;
        sendWord(4'h3, 1'b1);
        sendWord(4'hC, 1'b0);
        exp_cnt = 4;
        checkOutput("ovr_data", 32'(out_data), 32'h3);
        checkOutput("ovr_flag", 32'(overrun), 32'd1);
        checkOutput("ovr_cnt", 32'(word_cnt), expCnt());
        err_clr = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        err_clr = 1'b0;
        checkOutput("ovr_clr", 32'(overrun), 32'd0);
        out_ready = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);

        // Framing error: sync arrives on the third bit.
        applyStimulus(1'b1, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        sendWord(4'h9, 1'b1);
        exp_cnt = 5;
        checkOutput("frm_flag", 32'(frame_err), 32'd1);
        checkOutput("frm_data", 32'(out_data), 32'h9);
        checkOutput("frm_cnt", 32'(word_cnt), expCnt());
        applyStimulus(1'b0, 1'b0, 1'b0);
        err_clr = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        err_clr = 1'b0;
        checkOutput("frm_clr", 32'(frame_err), 32'd0);

        // Asynchronous reset in the middle of a word.
        out_ready = 1'b0;
        sendWord(4'h7, 1'b0);
        sendWord(4'h2, 1'b0);
        checkOutput("pre_rst_valid", 32'(out_valid), 32'd1);
        checkOutput("pre_rst_ovr", 32'(overrun), 32'd1);
        applyStimulus(1'b1, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b1);
        ser_valid = 1'b0;
        sync      = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        exp_cnt = 0;
        checkOutput("arst_data", 32'(out_data), 32'd0);
        checkOutput("arst_valid", 32'(out_valid), 32'd0);
        checkOutput("arst_ovr", 32'(overrun), 32'd0);
        checkOutput("arst_frame", 32'(frame_err), 32'd0);
        checkOutput("arst_cnt", 32'(word_cnt), 32'd0);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        sendWord(4'h6, 1'b1);
        exp_cnt = 1;
        checkOutput("six_data", 32'(out_data), 32'h6);
        checkOutput("six_cnt", 32'(word_cnt), expCnt());
        applyStimulus(1'b0, 1'b0, 1'b0);

        // Gaps inside 4'hE; handshake of the held word coincides with completion.
        out_ready = 1'b0;
        sendWord(4'h1, 1'b1);
        sb.push_back(4'hE);
        applyStimulus(1'b1, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1);
        out_ready = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0);
        ser_valid = 1'b0;
        exp_cnt   = 3;
        checkOutput("gap_data", 32'(out_data), 32'hE);
        checkOutput("gap_valid", 32'(out_valid), 32'd1);
        checkOutput("gap_ovr", 32'(overrun), 32'd0);
        checkOutput("gap_frame", 32'(frame_err), 32'd0);
        checkOutput("gap_cnt", 32'(word_cnt), expCnt());
        applyStimulus(1'b0, 1'b0, 1'b0);

        // Drop coinciding with err_clr: the error wins.
        out_ready = 1'b0;
        sendWord(4'h4, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        err_clr = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0);
        err_clr   = 1'b0;
        ser_valid = 1'b0;
        exp_cnt   = 4;
        checkOutput("clr_race_ovr", 32'(overrun), 32'd1);
        checkOutput("clr_race_data", 32'(out_data), 32'h4);
        out_ready = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("end_cnt", 32'(word_cnt), expCnt());
        checkOutput("sb_empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sipo_deser.md
# sipo_deser

Serial-in/parallel-out deserializer that consumes the MSB-first serial stream produced by the team's PISO serializer and rebuilds parallel words. Bits are qualified by a valid strobe and word-aligned by a sync pulse on the first (MSB) bit. Completed words go to a one-entry output holding register with a valid/ready handshake toward the downstream consumer. Overrun and framing errors are reported as sticky flags.

## Interface
- WIDTH, default 4, word width in bits (≥2)
- CNT_W, default 16, width of the optional word counter
- clk  input  1  clock, rising edge
- rst_n  input  1  reset: asynchronous, active-low
- ser_in  input  1  serial data bit, MSB of each word first
- ser_valid  input  1  ser_in carries a bit this cycle
- sync  input  1  marks the current bit as a word's MSB; ignored unless ser_valid=1
- out_data  output  WIDTH  assembled parallel word
- out_valid  output  1  out_data holds an unconsumed word
- out_ready  input  1  consumer accepts out_data this cycle
- overrun  output  1  sticky: a completed word was dropped
- frame_err  output  1  sticky: sync arrived mid-word
- err_clr  input  1  clears overrun and frame_err
- word_cnt  output  CNT_W  count of words delivered to the holding register (configuration-dependent)

## Operation
- Reset values: out_data=0, out_valid=0, overrun=0, frame_err=0, word_cnt=0. Internal shift register=0, bit counter=0, state=IDLE. A reset mid-word discards the partial word.
- FSM states: IDLE, SHIFT.
- IDLE: a bit with ser_valid=1 and sync=0 is discarded. A bit with ser_valid=1 and sync=1 is shifted in (shift_reg <= {shift_reg[WIDTH-2:0], ser_in}), the counter goes to 1, and the FSM moves to SHIFT.
- SHIFT: each ser_valid=1 cycle shifts one bit in and increments the counter. When the WIDTH-th bit is taken, the word completes, the counter clears, and the FSM returns to IDLE. A sync on the next cycle then starts a new word back-to-back, with no bubble.
- SHIFT with sync=1 and ser_valid=1: set frame_err, drop the partial word, and restart with this bit as the MSB (counter=1, remain in SHIFT).
- ser_valid=0 cycles hold all state; gaps inside a word are legal.
- Word completion:
  - If the holding register is empty, or out_valid&&out_ready in the same cycle: load out_data with the new word and set out_valid=1.
  - Otherwise drop the new word, keep the old word unchanged, and set overrun.
- out_valid clears on out_valid&&out_ready, unless a completion reloads the register in the same cycle.
- err_clr=1 clears both flags. If an error event coincides with err_clr, the error wins and the flag stays at 1.
- word_cnt increments on every load of the holding register and wraps at 2^CNT_W. Dropped words do not count.

## Timing
- All outputs are registered.
- Latency: the final bit is sampled at edge N; out_data and out_valid are visible after edge N.
- Alignment with the PISO: the serializer's data_out shows the MSB one cycle after its load cycle. The upstream controller therefore drives sync and ser_valid on that cycle, and holds ser_valid for WIDTH consecutive cycles.
- Sustained throughput: one word per WIDTH ser_valid cycles, with no overrun as long as out_ready is asserted at least once per word.

## Configuration
- SIPO_DESER_WORD_CNT_EN defined: word_cnt counter is instantiated as described above.
- Not defined: word_cnt is tied to 0 and no counter flops are synthesized. All other behaviour is identical.

## Structure
- Shared package sipo_deser_pkg contains:
  - the state enum (IDLE, SHIFT)
  - the bit-counter width, $clog2(WIDTH+1)
  - default parameter constants for WIDTH and CNT_W
- One natural sub-module, sipo_hold_reg: the one-entry valid/ready holding register, including overrun detection.
- Shift register, counter and FSM stay in the top module.

## Test plan
- WIDTH=4, out_ready=1; sync+valid then bits 1,0,1,1 on consecutive cycles → out_data=4'hB, out_valid=1 exactly one cycle after the 4th bit; word_cnt=1 when enabled.
- Back-to-back words 4'hA then 4'h5 with no gap and out_ready=1 → two deliveries 4 cycles apart, overrun=0.
- out_ready=0; send 4'h3 then 4'hC → out_data stays 4'h3, overrun=1; err_clr pulse → overrun=0.
- Send 2 bits of a word, then sync on the 3rd bit and send 4'h9 → frame_err=1, out_data=4'h9, the partial bits are lost.
- Assert rst_n=0 asynchronously mid-word (between clock edges) → all outputs 0 immediately; the next clean word 4'h6 is received correctly.
- Insert ser_valid=0 gaps inside word 4'hE, with out_valid&&out_ready coinciding with completion → out_data=4'hE, out_valid remains 1, no overrun.
